usb_boot_sequencer: RTL and testbench
=====================================

Name: usb_boot_sequencer

Overview:
- Sequences power-up, USB attach and warmboot hand-off for the iCE40 USB bootloader top.
- Holds the bootloader core in reset until the 48 MHz PLL is stably locked, then enables the USB pull-up.
- On a boot request, it waits for the SPI flash to go idle, detaches from USB for a fixed interval, then drives the SB_WARMBOOT select and BOOT lines.

Parameters:
- LOCK_FILTER_CYCLES, 4800: consecutive synchronized-lock cycles required before release (100 us at 48 MHz).
- DETACH_CYCLES, 480000: cycles usb_pu is held low before warmboot (10 ms).
- WARMBOOT_IMAGE, 2'b01: value driven on {wb_s1, wb_s0}.
- QUIESCE_MAX_CYCLES, 65536: timeout for the SPI idle wait (used only with QUIESCE_TIMEOUT_EN).

Ports:
- clk_48mhz  in  1  PLL output clock; sole clock.
- reset_n  in  1  asynchronous, active-low reset.
- pll_lock  in  1  raw PLL LOCK; asynchronous, 2-flop synchronized internally.
- boot_req  in  1  level from bootloader core; sampled only in RUN.
- spi_cs_n  in  1  flash chip select as driven by the core; high = flash idle.
- core_reset  out  1  active-high reset to the bootloader core.
- usb_pu  out  1  USB D+ pull-up enable.
- wb_boot  out  1  SB_WARMBOOT BOOT.
- wb_s1  out  1  SB_WARMBOOT S1.
- wb_s0  out  1  SB_WARMBOOT S0.
- seq_state  out  3  current state encoding, for LED/debug.

Behaviour:
- Reset (async, reset_n=0) puts the block in LOCKWAIT with outputs: core_reset=1, usb_pu=0, wb_boot=0, {wb_s1,wb_s0}=WARMBOOT_IMAGE, seq_state=0, all counters 0, sync flops 0.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- State encoding: LOCKWAIT=0, RUN=1, QUIESCE=2, DETACH=3, BOOT=4.
- LOCKWAIT:
  - The lock counter increments while lock_sync=1 and clears to 0 on any lock_sync=0.
  - When the counter reaches LOCK_FILTER_CYCLES-1 with lock_sync=1, go to RUN.
  - Counter width is clog2(LOCK_FILTER_CYCLES+1); the counter saturates and never wraps.
- RUN:
  - core_reset=0 and usb_pu=1, both from the first RUN cycle.
  - lock_sync=0 goes to LOCKWAIT and reasserts core_reset=1 and usb_pu=0 on the next cycle.
  - Otherwise boot_req=1 goes to QUIESCE. Lock loss has priority over boot_req when both occur in the same cycle.
- QUIESCE:
  - core_reset stays 0 so an in-flight SPI transaction can finish; usb_pu stays 1.
  - Two consecutive cycles of spi_cs_n=1 go to DETACH.
  - lock_sync=0 goes to LOCKWAIT.
  - Deasserting boot_req does not abort; the request is committed.
- DETACH:
  - core_reset=1 and usb_pu=0.
  - The detach counter counts DETACH_CYCLES cycles, then goes to BOOT.
  - pll_lock is ignored from this state onward.
- BOOT:
  - wb_boot=1 and is held; SB_WARMBOOT is level-sensitive.
  - Terminal state; left only by reset_n.
- Reset asserted mid-sequence returns the block immediately to LOCKWAIT defaults and clears wb_boot.
- The detach counter width is clog2(DETACH_CYCLES+1); it is cleared on entry to DETACH.

Optional Feature:
- Macro: QUIESCE_TIMEOUT_EN.
- Defined:
  - A QUIESCE cycle counter runs.
  - If spi_cs_n has not been seen high for two consecutive cycles within QUIESCE_MAX_CYCLES, the block forces the transition to DETACH.
  - Asserting core_reset there aborts the flash access.
- Undefined:
  - QUIESCE waits indefinitely for spi_cs_n idle.
  - No counter is synthesized.

Test Plan:
Bench parameters: LOCK_FILTER_CYCLES=8, DETACH_CYCLES=16, QUIESCE_MAX_CYCLES=32.
- Power-up: reset_n released, pll_lock=1 steady -> core_reset falls and usb_pu rises together, 8 cycles after lock_sync first reads 1 (2-cycle synchronizer delay plus filter); seq_state reads 1.
- Lock glitch: pll_lock=1 for 5 cycles, 0 for 1 cycle, then 1 -> filter restarts; release occurs 8 cycles after the glitch, not before.
- Boot, flash idle: in RUN with spi_cs_n=1, pulse boot_req for 1 cycle -> QUIESCE for 2 cycles, then DETACH with usb_pu=0 and core_reset=1 for exactly 16 cycles, then wb_boot=1 and {wb_s1,wb_s0}=01, held.
- Boot, flash busy: boot_req while spi_cs_n=0 for 10 cycles -> stays in QUIESCE with usb_pu=1 until spi_cs_n has been high for 2 cycles; with QUIESCE_TIMEOUT_EN and spi_cs_n stuck at 0 -> DETACH entered after 32 cycles.
- Lock loss: drop pll_lock in RUN -> core_reset=1 and usb_pu=0 by 3 cycles later; drop pll_lock in DETACH -> no effect, BOOT is still reached.
- Mid-sequence reset: assert reset_n=0 in DETACH and in BOOT -> all outputs return to reset values asynchronously, with wb_boot=0.

Source files
------------

// File: rtl/usb_boot_sequencer_if.sv
// usb_boot_sequencer_if: PLL lock, boot request, flash idle and reset/pull-up/warmboot lines of the boot sequencer.
interface usb_boot_sequencer_if;
   logic       pll_lock;
   logic       boot_req;
   logic       spi_cs_n;
   logic       core_reset;
   logic       usb_pu;
   logic       wb_boot;
   logic       wb_s1;
   logic       wb_s0;
   logic [2:0] seq_state;
   modport master (
      input  pll_lock, boot_req, spi_cs_n,
      output core_reset, usb_pu, wb_boot, wb_s1, wb_s0, seq_state
   );
   modport slave (
      output pll_lock, boot_req, spi_cs_n,
      input  core_reset, usb_pu, wb_boot, wb_s1, wb_s0, seq_state
   );
endinterface

// File: rtl/usb_boot_sequencer.sv
// usb_boot_sequencer: PLL-lock filtered power-up, USB attach and warmboot hand-off sequencer.
// Optional QUIESCE_TIMEOUT_EN bounds the wait for the SPI flash to go idle.
module usb_boot_sequencer #(
   parameter int         LOCK_FILTER_CYCLES = 4800,
   parameter int         DETACH_CYCLES      = 480000,
   parameter logic [1:0] WARMBOOT_IMAGE     = 2'b01,
   parameter int         QUIESCE_MAX_CYCLES = 65536
) (
   input logic                   clk_48mhz,
   input logic                   reset_n,
   usb_boot_sequencer_if.master  bus
);
   localparam int LW = $clog2(LOCK_FILTER_CYCLES + 1);
   localparam int DW = $clog2(DETACH_CYCLES + 1);
   typedef enum logic [2:0] {
      LOCKWAIT = 3'd0,
      RUN      = 3'd1,
      QUIESCE  = 3'd2,
      DETACH   = 3'd3,
      BOOT     = 3'd4
   } state_t;
   state_t state, nxt;
   logic lock_meta, lock_sync, cs_seen;
   logic lock_done, idle_done, det_done, q_timeout;
   logic [LW-1:0] lock_cnt;
   logic [DW-1:0] det_cnt;
   assign lock_done = lock_sync && lock_cnt == LW'(LOCK_FILTER_CYCLES - 1);
   assign idle_done = cs_seen && bus.spi_cs_n;
   assign det_done  = det_cnt == DW'(DETACH_CYCLES - 1);
`ifdef QUIESCE_TIMEOUT_EN
   localparam int QW = $clog2(QUIESCE_MAX_CYCLES + 1);
   logic [QW-1:0] q_cnt;
   assign q_timeout = q_cnt == QW'(QUIESCE_MAX_CYCLES - 1);
   always_ff @(posedge clk_48mhz or negedge reset_n)
      if (!reset_n) q_cnt <= '0;
      else          q_cnt <= (state == QUIESCE) ? q_cnt + 1'b1 : '0;
`else
   assign q_timeout = 1'b0;
`endif
   always_comb begin
      nxt = state;
      case (state)
         LOCKWAIT: nxt = lock_done ? RUN : LOCKWAIT;
         RUN:      nxt = !lock_sync ? LOCKWAIT : bus.boot_req ? QUIESCE : RUN;
         QUIESCE:  nxt = !lock_sync ? LOCKWAIT : (idle_done || q_timeout) ? DETACH : QUIESCE;
         DETACH:   nxt = det_done ? BOOT : DETACH;
         BOOT:     nxt = BOOT;
         default:  nxt = LOCKWAIT;
      endcase
   end
   // Outputs are registered from the next state so they change together with seq_state.
   always_ff @(posedge clk_48mhz or negedge reset_n)
      if (!reset_n) begin
         state          <= LOCKWAIT;
         lock_meta      <= 1'b0;
         lock_sync      <= 1'b0;
         cs_seen        <= 1'b0;
         lock_cnt       <= '0;
         det_cnt        <= '0;
         bus.core_reset <= 1'b1;
         bus.usb_pu     <= 1'b0;
         bus.wb_boot    <= 1'b0;
         bus.wb_s1      <= WARMBOOT_IMAGE[1];
         bus.wb_s0      <= WARMBOOT_IMAGE[0];
         bus.seq_state  <= 3'd0;
      end else begin
         lock_meta      <= bus.pll_lock;
         lock_sync      <= lock_meta;
         state          <= nxt;
         lock_cnt       <= (state == LOCKWAIT && lock_sync) ?
                           (lock_cnt == LW'(LOCK_FILTER_CYCLES) ? lock_cnt : lock_cnt + 1'b1) : '0;
         det_cnt        <= (state == DETACH) ? det_cnt + 1'b1 : '0;
         cs_seen        <= state == QUIESCE && bus.spi_cs_n;
         bus.core_reset <= !(nxt == RUN || nxt == QUIESCE);
         bus.usb_pu     <= nxt == RUN || nxt == QUIESCE;
         bus.wb_boot    <= nxt == BOOT;
         bus.wb_s1      <= WARMBOOT_IMAGE[1];
         bus.wb_s0      <= WARMBOOT_IMAGE[0];
         bus.seq_state  <= nxt;
      end
endmodule

// File: tb/tb_usb_boot_sequencer.sv
// tb_usb_boot_sequencer: vector table, corner-case sequences and random stimulus against a reference model.
module tb_usb_boot_sequencer;
   localparam int LOCKN = 8;
   localparam int DETN  = 16;
   localparam int QMAX  = 32;
   localparam logic [7:0] RST_OUT = 8'b1_0_0_01_000;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   usb_boot_sequencer_if bus();
   usb_boot_sequencer #(
      .LOCK_FILTER_CYCLES(LOCKN),
      .DETACH_CYCLES(DETN),
      .WARMBOOT_IMAGE(2'b01),
      .QUIESCE_MAX_CYCLES(QMAX)
   ) dut (
      .clk_48mhz(clk),
      .reset_n(reset_n),
      .bus(bus)
   );
   always #5 clk = ~clk;
   int n_cmp = 0;
   int n_bad = 0;
   // Reference model: phase number plus run lengths of the observed conditions.
   int  m_st, m_run, m_det, m_idle, m_qt;
   bit  h1, h2;
   function automatic void check(string name, logic [31:0] got, logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endfunction
   function automatic void model_reset();
      m_st = 0; m_run = 0; m_det = 0; m_idle = 0; m_qt = 0; h1 = 0; h2 = 0;
   endfunction
   function automatic void model_edge(bit pl, bit br, bit cs);
      bit ls;
      ls = h2;
      h2 = h1;
      h1 = pl;
      if (m_st == 0) begin
         m_run = ls ? m_run + 1 : 0;
         if (m_run >= LOCKN) begin m_st = 1; m_run = 0; end
      end else if (m_st == 1) begin
         if (!ls) m_st = 0;
         else if (br) begin m_st = 2; m_idle = 0; m_qt = 0; end
      end else if (m_st == 2) begin
         m_qt++;
         m_idle = cs ? m_idle + 1 : 0;
         if (!ls) m_st = 0;
         else if (m_idle >= 2) begin m_st = 3; m_det = 0; end
`ifdef QUIESCE_TIMEOUT_EN
         else if (m_qt >= QMAX) begin m_st = 3; m_det = 0; end
`endif
      end else if (m_st == 3) begin
         m_det++;
         if (m_det >= DETN) m_st = 4;
      end
   endfunction
   function automatic logic [7:0] model_out();
      logic live;
      live = m_st == 1 || m_st == 2;
      return {!live, live, m_st == 4, 2'b01, 3'(m_st)};
   endfunction
   function automatic logic [7:0] dut_out();
      return {bus.core_reset, bus.usb_pu, bus.wb_boot, bus.wb_s1, bus.wb_s0, bus.seq_state};
   endfunction
   task automatic tick();
      @(posedge clk);
      if (!reset_n) model_reset();
      else model_edge(bus.pll_lock, bus.boot_req, bus.spi_cs_n);
      #1;
      check("model", 32'(dut_out()), 32'(model_out()));
   endtask
   task automatic do_reset();
      reset_n = 1'b0;
      bus.pll_lock = 1'b0;
      bus.boot_req = 1'b0;
      bus.spi_cs_n = 1'b1;
      tick();
      tick();
      reset_n = 1'b1;
   endtask
   task automatic reach_run();
      int n = 0;
      do_reset();
      bus.pll_lock = 1'b1;
      while (bus.seq_state != 3'd1 && n < 40) begin tick(); n++; end
      check("powerup_cycles", 32'(n), 32'(2 + LOCKN));
   endtask
   typedef struct {
      logic       pll, br, cs;
      int         n;
      logic [2:0] st;
      logic       cr, pu, wb;
   } vec_t;
   vec_t tbl[9];
   initial begin
      int n;
      tbl[0] = '{1'b1, 1'b0, 1'b1, 2,  3'd0, 1'b1, 1'b0, 1'b0};
      tbl[1] = '{1'b1, 1'b0, 1'b1, 7,  3'd0, 1'b1, 1'b0, 1'b0};
      tbl[2] = '{1'b1, 1'b0, 1'b1, 1,  3'd1, 1'b0, 1'b1, 1'b0};
      tbl[3] = '{1'b1, 1'b1, 1'b1, 1,  3'd2, 1'b0, 1'b1, 1'b0};
      tbl[4] = '{1'b1, 1'b0, 1'b1, 1,  3'd2, 1'b0, 1'b1, 1'b0};
      tbl[5] = '{1'b1, 1'b0, 1'b1, 1,  3'd3, 1'b1, 1'b0, 1'b0};
      tbl[6] = '{1'b0, 1'b0, 1'b1, 15, 3'd3, 1'b1, 1'b0, 1'b0};
      tbl[7] = '{1'b0, 1'b0, 1'b1, 1,  3'd4, 1'b1, 1'b0, 1'b1};
      tbl[8] = '{1'b0, 1'b1, 1'b0, 5,  3'd4, 1'b1, 1'b0, 1'b1};
      do_reset();
      check("reset_out", 32'(dut_out()), 32'(RST_OUT));
      for (int i = 0; i < 9; i++) begin
         bus.pll_lock = tbl[i].pll;
         bus.boot_req = tbl[i].br;
         bus.spi_cs_n = tbl[i].cs;
         for (int k = 0; k < tbl[i].n; k++) tick();
         check($sformatf("vec%0d", i), 32'(dut_out()),
               32'({tbl[i].cr, tbl[i].pu, tbl[i].wb, 2'b01, tbl[i].st}));
      end
      #3 reset_n = 1'b0;
      #1 check("async_reset_boot", 32'(dut_out()), 32'(RST_OUT));
      do_reset();
      // Lock glitch restarts the filter.
      bus.pll_lock = 1'b1;
      repeat (5) tick();
      bus.pll_lock = 1'b0;
      tick();
      bus.pll_lock = 1'b1;
      n = 0;
      while (bus.core_reset && n < 40) begin tick(); n++; end
      check("glitch_release", 32'(n), 32'(10));
      check("glitch_pu", 32'(bus.usb_pu), 32'(1));
      // Flash busy holds QUIESCE.
      reach_run();
      bus.spi_cs_n = 1'b0;
      bus.boot_req = 1'b1;
      tick();
      bus.boot_req = 1'b0;
      repeat (10) tick();
      check("busy_state", 32'(bus.seq_state), 32'(2));
      check("busy_pu", 32'(bus.usb_pu), 32'(1));
      bus.spi_cs_n = 1'b1;
      tick();
      check("idle1_state", 32'(bus.seq_state), 32'(2));
      tick();
      check("idle2_state", 32'(bus.seq_state), 32'(3));
      // Lock loss in RUN.
      reach_run();
      bus.pll_lock = 1'b0;
      tick();
      tick();
      check("lockloss_2", 32'({bus.core_reset, bus.usb_pu}), 32'(2'b01));
      tick();
      check("lockloss_3", 32'({bus.core_reset, bus.usb_pu}), 32'(2'b10));
      // Reset in the middle of DETACH.
      reach_run();
      bus.boot_req = 1'b1;
      tick();
      bus.boot_req = 1'b0;
      repeat (5) tick();
      check("detach_state", 32'(bus.seq_state), 32'(3));
      #3 reset_n = 1'b0;
      #1 check("async_reset_detach", 32'(dut_out()), 32'(RST_OUT));
      // Stuck-busy flash.
      reach_run();
      bus.spi_cs_n = 1'b0;
      bus.boot_req = 1'b1;
      tick();
      bus.boot_req = 1'b0;
`ifdef QUIESCE_TIMEOUT_EN
      n = 0;
      while (bus.seq_state != 3'd3 && n < 100) begin tick(); n++; end
      check("quiesce_timeout", 32'(n), 32'(QMAX));
`else
      repeat (3 * QMAX) tick();
      check("quiesce_wait", 32'(bus.seq_state), 32'(2));
`endif
      // Random stimulus against the model.
      do_reset();
      for (int i = 0; i < 5000; i++) begin
         reset_n      = !($urandom % 300 == 0 || (bus.seq_state == 3'd4 && $urandom % 8 == 0));
         bus.pll_lock = $urandom % 60 != 0;
         bus.boot_req = $urandom % 20 == 0;
         bus.spi_cs_n = $urandom % 4 != 0;
         tick();
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
